// File: rtl/tmec_chien_search_serial_pkg.sv
// GF(2^M) helpers and state encoding for the serial
// Chien search stage.
package tmec_chien_search_serial_pkg;

  typedef enum logic {IDLE, RUN} chien_state_t;

  function automatic logic [15:0] bch_polynomial(
    input int m
  );
    logic [15:0] p;
    unique case (m)
      2, 3, 4, 6, 7, 15: p = 16'h0003;
      5, 11:             p = 16'h0005;
      8:                 p = 16'h001d;
      9:                 p = 16'h0011;
      10:                p = 16'h0009;
      12:                p = 16'h0053;
      13:                p = 16'h001b;
      14:                p = 16'h002b;
      16:                p = 16'h002d;
      default:           p = 16'h0000;
    endcase
    return p;
  endfunction

  function automatic logic bch_is_pentanomial(
    input int m
  );
    logic [15:0] p;
    int n;
    p = bch_polynomial(m);
    n = 0;
    for (int k = 0; k < 16; k++)
      if (p[k]) n++;
    return n == 4;
  endfunction

  // alpha^e in standard basis, e reduced mod 2^m-1
  function automatic logic [15:0] gf_alpha_pow(
    input int m,
    input int e
  );
    int v;
    int q;
    int red;
    red = (1 << m) | int'(bch_polynomial(m));
    q = e % ((1 << m) - 1);
    v = 1;
    for (int k = 0; k < q; k++) begin
      v = v << 1;
      if (((v >> m) & 1) == 1)
        v = v ^ red;
    end
    return 16'(v);
  endfunction

endpackage

// File: rtl/tmec_chien_search_serial_mult.sv
// Combinational multiply of a standard-basis GF(2^M)
// element by the constant alpha^P.
module gf_const_mult_alpha
  import tmec_chien_search_serial_pkg::*;
#(
  parameter int M = 4,
  parameter int P = 1
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  localparam logic [15:0] PFULL = bch_polynomial(M);
  localparam logic [M-1:0] POLY = PFULL[M-1:0];

  always_comb begin
    y = a;
    for (int k = 0; k < P; k++)
      y = {y[M-2:0], 1'b0} ^ (y[M-1] ? POLY : '0);
  end

endmodule

// File: rtl/tmec_chien_search_serial.sv
// Serial Chien search: one codeword position per
// enabled clock, highest-degree bit first.
module tmec_chien_search_serial
  import tmec_chien_search_serial_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3,
  parameter int N = 2**M - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ce,
  input  logic [M*(T+1)-1:0]      cNout,
  output logic                    ready,
  output logic                    valid,
  output logic                    err,
  output logic                    first,
  output logic                    last,
  output logic                    done,
  output logic [$clog2(T+2)-1:0]  err_count,
  output logic                    fail
);

  localparam int CW = $clog2(T+2);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int Q = 2**M - N;

  if (bch_is_pentanomial(M)) begin : g_pent_guard
    $error("pentanomial GF(2^M) not supported");
  end

  chien_state_t  state, state_nxt;
  logic [M-1:0]  r      [T+1];
  logic [M-1:0]  ld_val [T+1];
  logic [M-1:0]  st_val [T+1];
  logic [PW-1:0] pos;
  logic [CW-1:0] acc, acc_nxt;
  logic [CW-1:0] deg, deg_ld;
  logic [M-1:0]  sum;
  logic          run, beat, fin, load;

  assign ld_val[0] = cNout[0 +: M];
  assign st_val[0] = r[0];

  // Load pre-rotates so position 0 lands on x^(N-1)
  for (genvar i = 1; i <= T; i++) begin : g_coef
    gf_const_mult_alpha #(
      .M (M),
      .P ((i*Q) % (2**M - 1))
    ) u_ld (
      .a (cNout[i*M +: M]),
      .y (ld_val[i])
    );
    gf_const_mult_alpha #(
      .M (M),
      .P (i)
    ) u_st (
      .a (r[i]),
      .y (st_val[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i <= T; i++)
      sum = sum ^ r[i];
  end

  always_comb begin
    deg_ld = '0;
    for (int i = 0; i <= T; i++)
      if (cNout[i*M +: M] != '0)
        deg_ld = CW'(i);
  end

  assign run   = (state == RUN);
  assign valid = run;
  assign err   = run && (sum == '0);
  assign first = run && (pos == '0);
  assign last  = run && (pos == PW'(N-1));
  assign beat  = run && ce;
  assign fin   = beat && last;
  assign ready = !run || fin;
  assign load  = start && ready;

  assign acc_nxt = (acc == CW'(T+1)) ?
                   acc : acc + CW'(err);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (fin) state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos       <= '0;
      acc       <= '0;
      deg       <= '0;
      done      <= 1'b0;
      err_count <= '0;
      fail      <= 1'b0;
      for (int i = 0; i <= T; i++)
        r[i] <= '0;
    end else begin
      done <= fin;
      if (fin) begin
        err_count <= acc_nxt;
        fail      <= (r[0] == '0) || (acc_nxt != deg);
      end
      if (load) begin
        for (int i = 0; i <= T; i++)
          r[i] <= ld_val[i];
        pos <= '0;
        acc <= '0;
        deg <= deg_ld;
      end else if (beat) begin
        for (int i = 0; i <= T; i++)
          r[i] <= st_val[i];
        pos <= pos + PW'(1);
        acc <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tmec_chien_search_serial.sv
// Bench for the serial Chien search: directed and
// random words against a direct polynomial evaluator.
module tb_tmec_chien_search_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, ce;
  logic [15:0] cn;
  logic        ready, valid, err, first, last;
  logic        done, fail;
  logic [2:0]  err_count;

  logic        start_s, ce_s;
  logic [15:0] cn_s;
  logic        ready_s, valid_s, err_s, first_s, last_s;
  logic        done_s, fail_s;
  logic [2:0]  err_count_s;

  int checks = 0;
  int errors = 0;
  int aexp [15];
  int alog [16];

  tmec_chien_search_serial #(
    .M (4), .T (3), .N (15)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .ce (ce), .cNout (cn), .ready (ready),
    .valid (valid), .err (err), .first (first),
    .last (last), .done (done),
    .err_count (err_count), .fail (fail)
  );

  tmec_chien_search_serial #(
    .M (4), .T (3), .N (10)
  ) dut_s (
    .clk (clk), .reset (reset), .start (start_s),
    .ce (ce_s), .cNout (cn_s), .ready (ready_s),
    .valid (valid_s), .err (err_s), .first (first_s),
    .last (last_s), .done (done_s),
    .err_count (err_count_s), .fail (fail_s)
  );

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return aexp[(alog[a] + alog[b]) % 15];
  endfunction

  // Lambda(alpha^-(n-1-p)) == 0
  function automatic bit m_root(logic [15:0] cb, int n, int p);
    int e;
    int v;
    logic [3:0] c;
    e = (15 - (n - 1 - p)) % 15;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      c = cb[i*4 +: 4];
      v = v ^ gmul(int'(c), aexp[(i*e) % 15]);
    end
    return v == 0;
  endfunction

  function automatic logic [14:0] m_pat(logic [15:0] cb, int n);
    logic [14:0] r;
    r = '0;
    for (int p = 0; p < n; p++) r[p] = m_root(cb, n, p);
    return r;
  endfunction

  function automatic int m_count(logic [15:0] cb, int n);
    int c;
    c = 0;
    for (int p = 0; p < n; p++)
      if (m_root(cb, n, p) && c < 4) c++;
    return c;
  endfunction

  function automatic bit m_fail(logic [15:0] cb, int n);
    int d;
    d = 0;
    for (int i = 0; i < 4; i++)
      if (cb[i*4 +: 4] != 4'd0) d = i;
    return (cb[3:0] == 4'd0) || (m_count(cb, n) != d);
  endfunction

  // Product of (1 + X_j x) over k distinct locators
  function automatic logic [15:0] rand_lambda(int k, int maxj);
    int c [4];
    int used;
    int j;
    logic [15:0] r;
    c = '{1, 0, 0, 0};
    used = 0;
    for (int n = 0; n < k; n++) begin
      do j = $urandom_range(maxj); while (used[j]);
      used[j] = 1'b1;
      for (int i = 3; i >= 1; i--)
        c[i] = c[i] ^ gmul(aexp[j], c[i-1]);
    end
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(c[i]);
    return r;
  endfunction

  task automatic run15(
    input  logic [15:0] cb,
    input  bit          preload,
    input  int          sp,
    input  int          sn,
    input  bit          chain,
    input  logic [15:0] cb2,
    output logic [14:0] oerr,
    output int          obad,
    output logic        pdone,
    output logic [2:0]  pcnt,
    output logic        pfail,
    output logic        odone,
    output logic [2:0]  ocnt,
    output logic        ofail
  );
    logic [3:0] snap;
    oerr = '0; obad = 0;
    pdone = 0; pcnt = 0; pfail = 0;
    odone = 0; ocnt = 0; ofail = 0;
    if (!preload) begin
      if (ready !== 1'b1) obad++;
      start = 1'b1; cn = cb; ce = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    for (int p = 0; p < 15; p++) begin
      @(negedge clk);
      if (valid !== 1'b1 || first !== (p == 0) ||
          last !== (p == 14) || ready !== (p == 14))
        obad++;
      if (p == 0) begin
        pdone = done; pcnt = err_count; pfail = fail;
      end else if (done !== 1'b0) obad++;
      oerr[p] = err;
      if (p == sp) begin
        snap = {valid, err, first, last};
        ce = 1'b0;
        for (int s = 0; s < sn; s++) begin
          @(posedge clk); #1; @(negedge clk);
          if ({valid, err, first, last} !== snap ||
              ready !== 1'b0 || done !== 1'b0)
            obad++;
        end
        ce = 1'b1;
      end
      if (p == 14 && chain) begin
        start = 1'b1; cn = cb2;
      end
      @(posedge clk); #1; start = 1'b0;
    end
    if (!chain) begin
      @(negedge clk);
      odone = done; ocnt = err_count; ofail = fail;
      if (valid !== 1'b0 || ready !== 1'b1) obad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ce = 1'b0; cn = '0;
    start_s = 1'b0; ce_s = 1'b0; cn_s = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, valid, err, first, last, done,
         err_count, fail} !== 10'b10000_0_000_0) begin
      errors++;
      $display("FAIL reset15 got %b want 1000000000",
        {ready, valid, err, first, last, done, err_count, fail});
    end
    checks++;
    if ({ready_s, valid_s, done_s, err_count_s,
         fail_s} !== 7'b100_000_0) begin
      errors++;
      $display("FAIL reset10 got %b want 1000000",
        {ready_s, valid_s, done_s, err_count_s, fail_s});
    end
  endtask

  task automatic check_word(
    input string       nm,
    input logic [15:0] cb,
    input logic [14:0] oerr,
    input int          obad,
    input logic        odone,
    input logic [2:0]  ocnt,
    input logic        ofail
  );
    checks++;
    if (obad != 0 || odone !== 1'b1) begin
      errors++;
      $display("FAIL %s_seq got bad=%0d done=%b want 0/1",
        nm, obad, odone);
    end
    checks++;
    if (oerr !== m_pat(cb, 15)) begin
      errors++;
      $display("FAIL %s_err got %h want %h",
        nm, oerr, m_pat(cb, 15));
    end
    checks++;
    if (ocnt !== 3'(m_count(cb, 15)) ||
        ofail !== m_fail(cb, 15)) begin
      errors++;
      $display("FAIL %s_res got %0d/%b want %0d/%b", nm,
        ocnt, ofail, m_count(cb, 15), m_fail(cb, 15));
    end
  endtask

  task automatic test_identity();
    logic [14:0] e; int b;
    logic pd, pf, od, of; logic [2:0] pc, oc;
    run15(16'h0001, 0, -1, 0, 0, 0, e, b,
          pd, pc, pf, od, oc, of);
    check_word("ident", 16'h0001, e, b, od, oc, of);
    checks++;
    if (e !== 15'h0 || oc !== 3'd0 || of !== 1'b0) begin
      errors++;
      $display("FAIL ident_lit got %h/%0d/%b want 0/0/0",
        e, oc, of);
    end
  endtask

  task automatic test_first_root();
    logic [14:0] e; int b;
    logic pd, pf, od, of; logic [2:0] pc, oc;
    run15(16'h0091, 0, -1, 0, 0, 0, e, b,
          pd, pc, pf, od, oc, of);
    check_word("first", 16'h0091, e, b, od, oc, of);
    checks++;
    if (e !== 15'h0001 || oc !== 3'd1 || of !== 1'b0) begin
      errors++;
      $display("FAIL first_lit got %h/%0d/%b want 0001/1/0",
        e, oc, of);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] e; int b;
    logic pd, pf, od, of; logic [2:0] pc, oc;
    run15(16'h0011, 0, -1, 0, 1, 16'h0091, e, b,
          pd, pc, pf, od, oc, of);
    checks++;
    if (b != 0 || e !== 15'h4000) begin
      errors++;
      $display("FAIL b2b_w1 got bad=%0d err=%h want 0/4000",
        b, e);
    end
    run15(16'h0091, 1, -1, 0, 0, 0, e, b,
          pd, pc, pf, od, oc, of);
    checks++;
    if (pd !== 1'b1 || pc !== 3'd1 || pf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got %b/%0d/%b want 1/1/0",
        pd, pc, pf);
    end
    check_word("b2b_w2", 16'h0091, e, b, od, oc, of);
  endtask

  task automatic test_fail_cases();
    logic [14:0] e; int b;
    logic pd, pf, od, of; logic [2:0] pc, oc;
    run15(16'h1011, 0, -1, 0, 0, 0, e, b,
          pd, pc, pf, od, oc, of);
    check_word("nodist", 16'h1011, e, b, od, oc, of);
    checks++;
    if (of !== 1'b1 || oc === 3'd3) begin
      errors++;
      $display("FAIL nodist_lit got %0d/%b want !=3/1", oc, of);
    end
    run15(16'h0000, 0, -1, 0, 0, 0, e, b,
          pd, pc, pf, od, oc, of);
    check_word("zero", 16'h0000, e, b, od, oc, of);
    checks++;
    if (e !== 15'h7fff || oc !== 3'd4 || of !== 1'b1) begin
      errors++;
      $display("FAIL zero_lit got %h/%0d/%b want 7fff/4/1",
        e, oc, of);
    end
  endtask

  task automatic test_stall();
    logic [14:0] e0, e1; int b;
    logic pd, pf, od, of0, of1; logic [2:0] pc, oc0, oc1;
    logic [15:0] cb;
    cb = rand_lambda(3, 14);
    run15(cb, 0, -1, 0, 0, 0, e0, b,
          pd, pc, pf, od, oc0, of0);
    check_word("nostall", cb, e0, b, od, oc0, of0);
    run15(cb, 0, 5, 3, 0, 0, e1, b,
          pd, pc, pf, od, oc1, of1);
    check_word("stall", cb, e1, b, od, oc1, of1);
    checks++;
    if (e1 !== e0 || oc1 !== oc0 || of1 !== of0) begin
      errors++;
      $display("FAIL stall_same got %h/%0d want %h/%0d",
        e1, oc1, e0, oc0);
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] e; int b;
    logic pd, pf, od, of; logic [2:0] pc, oc;
    logic [15:0] cb;
    run15(16'h0091, 0, -1, 0, 0, 0, e, b,
          pd, pc, pf, od, oc, of);
    start = 1'b1; cn = 16'h0011; ce = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, valid, done, err_count} !== 6'b100_000) begin
      errors++;
      $display("FAIL rstmid got %b want 100000",
        {ready, valid, done, err_count});
    end
    cb = rand_lambda(2, 14);
    run15(cb, 0, -1, 0, 0, 0, e, b,
          pd, pc, pf, od, oc, of);
    check_word("after_rst", cb, e, b, od, oc, of);
  endtask

  task automatic test_random();
    logic [14:0] e; int b;
    logic pd, pf, od, of; logic [2:0] pc, oc;
    logic [15:0] cb;
    for (int w = 0; w < 20; w++) begin
      if ($urandom_range(3) == 0) cb = 16'($urandom);
      else cb = rand_lambda($urandom_range(3), 14);
      run15(cb, 0, (w % 3 == 0) ? $urandom_range(14) : -1,
            $urandom_range(1, 3), 0, 0, e, b,
            pd, pc, pf, od, oc, of);
      check_word("rand", cb, e, b, od, oc, of);
    end
  endtask

  task automatic test_shortened();
    logic [15:0] cb;
    logic [9:0]  e;
    int          bad;
    for (int w = 0; w < 4; w++) begin
      cb = (w == 0) ? 16'h00a1 : rand_lambda($urandom_range(3), 9);
      e = '0; bad = 0;
      @(negedge clk);
      start_s = 1'b1; cn_s = cb; ce_s = 1'b1;
      @(posedge clk); #1; start_s = 1'b0;
      for (int p = 0; p < 10; p++) begin
        @(negedge clk);
        if (valid_s !== 1'b1 || first_s !== (p == 0) ||
            last_s !== (p == 9)) bad++;
        e[p] = err_s;
        @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (bad != 0 || done_s !== 1'b1 ||
          e !== m_pat(cb, 10)) begin
        errors++;
        $display("FAIL short_err got %h bad=%0d want %h",
          e, bad, m_pat(cb, 10));
      end
      checks++;
      if (err_count_s !== 3'(m_count(cb, 10)) ||
          fail_s !== m_fail(cb, 10)) begin
        errors++;
        $display("FAIL short_res got %0d/%b want %0d/%b",
          err_count_s, fail_s, m_count(cb, 10), m_fail(cb, 10));
      end
      if (w == 0) begin
        checks++;
        if (e !== 10'h001 || err_count_s !== 3'd1) begin
          errors++;
          $display("FAIL short_lit got %h/%0d want 001/1",
            e, err_count_s);
        end
      end
    end
  endtask

  initial begin
    int a;
    a = 1;
    for (int k = 0; k < 15; k++) begin
      aexp[k] = a; alog[a] = k;
      a = a << 1;
      if (a >= 16) a = a ^ 19;
    end
    alog[0] = 0;
    test_reset();
    test_identity();
    test_first_root();
    test_back_to_back();
    test_fail_cases();
    test_stall();
    test_reset_mid();
    test_random();
    test_shortened();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
